ram_8_sequencer: RTL

RAM_8_SEQUENCER -- requirements
Module: ram_8_sequencer

---
 rtl/ram_8_sequencer.sv | 93 +++++++++
 1 files changed

// File: rtl/ram_8_sequencer.sv
// Sequencer in front of an 8x16 RAM: serves single-word read/write requests
// and can sweep all eight words to zero.
module ram_8_sequencer (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_address,
  input  logic [15:0] req_data,
  input  logic        clear_start,
  output logic        clear_busy,
  output logic        resp_valid,
  output logic [15:0] resp_data,
  output logic [15:0] ram_in,
  output logic [2:0]  ram_address,
  output logic        ram_load,
  input  logic [15:0] ram_out,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    CLEAR  = 2'd2
  } state_t;

  state_t     state;
  logic [2:0] count;
  logic       access_write;

  // Handshake: a request transfers on a rising edge with req_valid && req_ready;
  // ready is only offered in IDLE when no clear is requested, and a pending
  // clear_start wins over a simultaneous request.
  assign req_ready = (state == IDLE) && !clear_start && reset_n;
  assign fsm_state = state;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      count        <= 3'd0;
      access_write <= 1'b0;
      ram_load     <= 1'b0;
      ram_address  <= 3'd0;
      ram_in       <= 16'h0000;
      resp_valid   <= 1'b0;
      resp_data    <= 16'h0000;
      clear_busy   <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (clear_start) begin
            state       <= CLEAR;
            count       <= 3'd0;
            ram_address <= 3'd0;
            ram_in      <= 16'h0000;
            ram_load    <= 1'b1;
            clear_busy  <= 1'b1;
          end else if (req_valid) begin
            state        <= ACCESS;
            ram_address  <= req_address;
            ram_in       <= req_data;
            ram_load     <= req_write;
            access_write <= req_write;
          end
        end
        ACCESS: begin
          // A write lands in the RAM on this edge; a read samples ram_out here.
          state    <= IDLE;
          ram_load <= 1'b0;
          if (!access_write) begin
            resp_data  <= ram_out;
            resp_valid <= 1'b1;
          end
        end
        CLEAR: begin
          if (count == 3'd7) begin
            state      <= IDLE;
            count      <= 3'd0;
            ram_load   <= 1'b0;
            clear_busy <= 1'b0;
          end else begin
            count       <= count + 3'd1;
            ram_address <= count + 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
